// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter: active-low REQ/GNT pairs, bus-idle detection from
// FRAME/IRDY, preemption during a transaction and a grant timeout for idle masters.
module pci_bus_arbiter #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned TIMEOUT   = 16,
  localparam int unsigned OW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] REQ,
  input  logic                 FRAME,
  input  logic                 IRDY,
  output logic [N_MASTERS-1:0] GNT,
  output logic [OW-1:0]        owner,
  output logic                 owner_valid,
  output logic                 timeout
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic                 owner_valid_q, owner_valid_d;
  logic                 timeout_q, timeout_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [TW-1:0]        timer_q, timer_d;

  logic [N_MASTERS-1:0] req_act;
  logic                 win_found;
  logic [OW-1:0]        win_idx;
  int unsigned          cand;
  logic                 bus_idle;
  logic                 others_req;
  logic [OW-1:0]        ptr_after_owner;

  assign req_act         = ~REQ;
  assign bus_idle        = FRAME & IRDY;
  assign others_req      = |(req_act & ~(N_MASTERS'(1) << owner_q));
  assign ptr_after_owner = (owner_q == OW'(N_MASTERS - 1)) ? '0 : owner_q + OW'(1);

  // First active requester scanning upward from ptr, wrapping at N_MASTERS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      cand = (32'(ptr_q) + k) % N_MASTERS;
      if (!win_found && req_act[OW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = OW'(cand);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '1;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      ptr_q         <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      timeout_q     <= timeout_d;
      ptr_q         <= ptr_d;
      timer_q       <= timer_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    timeout_d     = 1'b0;
    ptr_d         = ptr_q;
    timer_d       = timer_q;

    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        gnt_d         = '1;
        owner_valid_d = 1'b0;
        state_d       = ST_IDLE;
        if (win_found) begin
          gnt_d[win_idx] = 1'b0;
          owner_d        = win_idx;
          owner_valid_d  = 1'b1;
          timer_d        = '0;
          state_d        = ST_GRANT;
        end
      end

      ST_GRANT: begin
        owner_valid_d = 1'b1;
        if (!FRAME) begin
          state_d = ST_BUSY;
        end else if (!req_act[owner_q] || (timer_q == TW'(TIMEOUT - 1))) begin
          // Withdrawal or timer expiry both release the bus through GAP.
          timeout_d     = req_act[owner_q];
          gnt_d         = '1;
          owner_valid_d = 1'b0;
          ptr_d         = ptr_after_owner;
          state_d       = ST_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_BUSY: begin
        owner_valid_d = 1'b1;
        if (bus_idle) begin
          gnt_d         = '1;
          owner_valid_d = 1'b0;
          ptr_d         = ptr_after_owner;
          state_d       = ST_GAP;
        end else if (others_req) begin
          gnt_d[owner_q] = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign GNT         = gnt_q;
  assign owner       = owner_q;
  assign owner_valid = owner_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter: expected outputs are queued before each
// clock and compared, one entry per cycle, just after the edge.
module tb_pci_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] REQ;
  logic       FRAME;
  logic       IRDY;
  logic [3:0] GNT;
  logic [1:0] owner;
  logic       owner_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  always #5 clock = ~clock;

  pci_bus_arbiter #(.N_MASTERS(4), .TIMEOUT(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .REQ        (REQ),
    .FRAME      (FRAME),
    .IRDY       (IRDY),
    .GNT        (GNT),
    .owner      (owner),
    .owner_valid(owner_valid),
    .timeout    (timeout)
  );

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] o,
                            input logic ov, input logic to);
    exp_q.push_back({g, o, ov, to});
    tag_q.push_back(tag);
  endtask

  // Advance one clock and compare the oldest queued expectation.
  task automatic tick();
    logic [7:0] e;
    logic [7:0] obs;
    string      t;
    @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {GNT, owner, owner_valid, timeout};
      n_cmp++;
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: GNT/owner/owner_valid/timeout observed=%b/%b/%b/%b expected=%b/%b/%b/%b",
               t, obs[7:4], obs[3:2], obs[1], obs[0], e[7:4], e[3:2], e[1], e[0]);
      end
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] g, input logic [1:0] o,
                     input logic ov, input logic to);
    expect_out(tag, g, o, ov, to);
    tick();
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] g;
    int         nm;
    one   = 4'b0001;
    reset = 1'b1;
    REQ   = 4'b1111;
    FRAME = 1'b1;
    IRDY  = 1'b1;
    cyc("reset0", 4'b1111, 2'd0, 1'b0, 1'b0);
    cyc("reset1", 4'b1111, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Single request, 3-clock transaction, then GAP and IDLE.
    REQ = 4'b1110;
    cyc("t1_grant", 4'b1110, 2'd0, 1'b1, 1'b0);
    REQ = 4'b1111; FRAME = 1'b0; IRDY = 1'b0;
    repeat (3) cyc("t1_busy", 4'b1110, 2'd0, 1'b1, 1'b0);
    FRAME = 1'b1; IRDY = 1'b1;
    cyc("t1_gap", 4'b1111, 2'd0, 1'b0, 1'b0);
    cyc("t1_idle", 4'b1111, 2'd0, 1'b0, 1'b0);

    // Round robin from a fresh pointer with every master requesting.
    reset = 1'b1;
    cyc("rr_reset", 4'b1111, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    REQ = 4'b0000;
    cyc("rr_grant0", 4'b1110, 2'd0, 1'b1, 1'b0);
    for (int m = 0; m < 4; m++) begin
      g  = ~(one << m);
      nm = (m + 1) % 4;
      FRAME = 1'b0; IRDY = 1'b0;
      cyc("rr_busy", g, 2'(m), 1'b1, 1'b0);
      cyc("rr_preempt", 4'b1111, 2'(m), 1'b1, 1'b0);
      FRAME = 1'b1; IRDY = 1'b1;
      cyc("rr_gap", 4'b1111, 2'(m), 1'b0, 1'b0);
      cyc("rr_grant", ~(one << nm), 2'(nm), 1'b1, 1'b0);
    end
    REQ = 4'b1111;
    cyc("rr_wd_gap", 4'b1111, 2'd0, 1'b0, 1'b0);
    cyc("rr_wd_idle", 4'b1111, 2'd0, 1'b0, 1'b0);

    // Timeout: 16 clocks of grant on an idle bus, then revocation and re-grant.
    REQ = 4'b1011;
    cyc("to_grant", 4'b1011, 2'd2, 1'b1, 1'b0);
    repeat (15) cyc("to_hold", 4'b1011, 2'd2, 1'b1, 1'b0);
    cyc("to_revoke", 4'b1111, 2'd2, 1'b0, 1'b1);
    cyc("to_regrant", 4'b1011, 2'd2, 1'b1, 1'b0);

    // FRAME asserted on the expiry edge wins over the timeout.
    repeat (15) cyc("race_hold", 4'b1011, 2'd2, 1'b1, 1'b0);
    FRAME = 1'b0; IRDY = 1'b0;
    cyc("race_busy", 4'b1011, 2'd2, 1'b1, 1'b0);
    FRAME = 1'b1; IRDY = 1'b1; REQ = 4'b1111;
    cyc("race_gap", 4'b1111, 2'd2, 1'b0, 1'b0);
    cyc("race_idle", 4'b1111, 2'd2, 1'b0, 1'b0);

    // Withdrawal before FRAME: GAP without timeout.
    REQ = 4'b1011;
    cyc("wd_grant", 4'b1011, 2'd2, 1'b1, 1'b0);
    REQ = 4'b1111;
    cyc("wd_gap", 4'b1111, 2'd2, 1'b0, 1'b0);
    cyc("wd_idle", 4'b1111, 2'd2, 1'b0, 1'b0);

    // Withdrawal and FRAME on the same edge: transaction starts.
    REQ = 4'b1011;
    cyc("wdf_grant", 4'b1011, 2'd2, 1'b1, 1'b0);
    REQ = 4'b1111; FRAME = 1'b0; IRDY = 1'b0;
    cyc("wdf_busy", 4'b1011, 2'd2, 1'b1, 1'b0);
    FRAME = 1'b1; IRDY = 1'b1;
    cyc("wdf_gap", 4'b1111, 2'd2, 1'b0, 1'b0);
    cyc("wdf_idle", 4'b1111, 2'd2, 1'b0, 1'b0);

    // Preemption of master 0 by master 1 during a transaction.
    reset = 1'b1;
    cyc("pre_reset", 4'b1111, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    REQ = 4'b1110;
    cyc("pre_grant0", 4'b1110, 2'd0, 1'b1, 1'b0);
    FRAME = 1'b0; IRDY = 1'b0;
    cyc("pre_busy", 4'b1110, 2'd0, 1'b1, 1'b0);
    REQ = 4'b1100;
    cyc("pre_revoke", 4'b1111, 2'd0, 1'b1, 1'b0);
    cyc("pre_finish", 4'b1111, 2'd0, 1'b1, 1'b0);
    FRAME = 1'b1; IRDY = 1'b1;
    cyc("pre_gap", 4'b1111, 2'd0, 0, 1'b0);
    REQ = 4'b1101;
    cyc("pre_grant1", 4'b1101, 2'd1, 1'b1, 1'b0);

    // Reset in the middle of a transaction, then a request from master 3.
    FRAME = 1'b0; IRDY = 1'b0;
    cyc("rb_busy", 4'b1101, 2'd1, 1'b1, 1'b0);
    reset = 1'b1;
    cyc("rb_reset", 4'b1111, 2'd0, 1'b0, 1'b0);
    reset = 1'b0; FRAME = 1'b1; IRDY = 1'b1; REQ = 4'b0111;
    cyc("rb_grant3", 4'b0111, 2'd3, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
Central PCI arbiter that shares the AD/CBE/FRAME/IRDY bus between up to N initiators using active-low REQ/GNT pairs. Round-robin fairness, bus-idle detection from FRAME/IRDY, and a grant timeout for masters that never start a transaction. Sits beside the target devices on the shared bus; targets (DEVSEL/TRDY) are not touched.

Parameters:
N_MASTERS, 4, number of initiators (2..8)
TIMEOUT, 16, clocks a granted master may leave the bus idle before its grant is revoked (>=2)
OW, $clog2(N_MASTERS), owner index width (internal; minimum 1)

Ports:
clock  input  1  bus clock, all logic on rising edge
reset  input  1  synchronous, active-high
REQ  input  N_MASTERS  per-master request, active low
FRAME  input  1  bus FRAME, active low
IRDY  input  1  bus IRDY, active low
GNT  output  N_MASTERS  per-master grant, active low, registered
owner  output  OW  index of current/last granted master
owner_valid  output  1  high while a master holds or is finishing ownership (GRANT, BUSY)
timeout  output  1  one-clock pulse when a grant is revoked by timeout

Behaviour:
- Reset: sampled at a rising edge. Next edge: GNT all 1, owner 0, owner_valid 0, timeout 0, ptr 0, timer 0, state IDLE. Applies mid-transaction; no completion wait.
- Bus idle: FRAME==1 && IRDY==1.
- Never more than one GNT bit low. Every grant change passes through GAP (all GNT high for exactly one clock).
- Winner selection (IDLE, GAP): first requester with REQ low, scanning ptr, ptr+1, ... mod N_MASTERS.
- States:
  IDLE: GNT all 1. Any REQ low -> winner w: GNT[w]=0, owner=w, timer=0 -> GRANT. Latency REQ sampled low to GNT low = 1 clock.
  GRANT: GNT[owner]=0, owner_valid=1. Priority order: FRAME==0 -> BUSY; else REQ[owner]==1 (withdrawn) -> GAP; else timer==TIMEOUT-1 -> GAP with timeout pulse; else timer++.
  BUSY: transaction in progress. GNT[owner] stays 0 while no other REQ is low. Any other REQ low -> GNT[owner]=1 next edge (preemption; owner finishes current transaction, stays in BUSY). Bus idle sampled -> GAP.
  GAP: GNT all 1, owner_valid=0, ptr=(owner+1) mod N_MASTERS. Winner chosen with updated ptr: requester present -> GRANT next edge, else IDLE.
- timeout: high exactly on the clock GNT goes high for a timeout revocation; otherwise 0.
- Simultaneous: FRAME low and timer expiry on same edge -> BUSY (FRAME wins, no timeout). REQ withdrawn and FRAME low same edge -> BUSY.
- Back-to-back: FRAME already low at entry to GRANT (bus not idle from previous master) is treated as the new master's start; bench must not drive that.
- ptr wraps N_MASTERS-1 -> 0. REQ bits X/Z treated as deasserted (1).
- Minimum grant-to-grant spacing: 1 GAP clock.

Test Plan:
1. Single request: REQ=1110 at edge k -> GNT=1110 at k+1, owner=0; FRAME low 3 clocks then idle -> GNT=1111 for one clock (GAP) -> IDLE, ptr=1.
2. Round robin: REQ=0000 held, each master runs one 2-clock FRAME burst -> grant order 0,1,2,3,0 with one all-ones GAP clock between grants.
3. Timeout: REQ=1011, FRAME held 1 -> GNT=1011 for exactly 16 clocks, timeout pulse on revocation, GNT=1111, ptr=3; REQ still low -> GNT=1011 again after GAP.
4. Preemption: master 0 in BUSY, REQ goes 1100 -> GNT[0]=1 next edge, owner stays 0, owner_valid 1 until FRAME=1,IRDY=1 sampled, GAP, then GNT=1101.
5. Withdrawal/race: master 2 granted, REQ[2]=1 before FRAME -> GAP, no timeout; separate run with FRAME=0 on expiry edge -> BUSY, timeout=0.
6. Reset mid-BUSY: reset=1 one clock -> GNT=1111, owner_valid=0, owner=0 next edge; REQ=0111 after reset -> GNT=0111 after one clock (ptr restarted at 0, scan reaches 3).
